// File: rtl/line_draw_ctrl_if.sv
// Handshake bundles for the line controller: command input (decoder -> controller)
// and pixel write output (controller -> framebuffer).
interface line_cmd_if #(
  parameter int unsigned COLOR_W = 16
);
  logic               valid;
  logic               ready;
  logic [15:0]        x1;
  logic [15:0]        y1;
  logic [15:0]        x2;
  logic [15:0]        y2;
  logic [COLOR_W-1:0] color;

  modport master (output valid, x1, y1, x2, y2, color, input ready);
  modport slave  (input valid, x1, y1, x2, y2, color, output ready);
endinterface

interface line_pix_if #(
  parameter int unsigned COLOR_W = 16
);
  logic               valid;
  logic               ready;
  logic [15:0]        x;
  logic [15:0]        y;
  logic [COLOR_W-1:0] color;

  modport master (output valid, x, y, color, input ready);
  modport slave  (input valid, x, y, color, output ready);
endinterface

// File: rtl/line_draw_ctrl.sv
// Line command sequencer between the command decoder, the pixel stepper and the framebuffer.
// Optional macro LINE_CLIP_EN suppresses writes for pixels outside SCREEN_W x SCREEN_H.
module line_draw_ctrl #(
  parameter int unsigned COLOR_W = 16
`ifdef LINE_CLIP_EN
  ,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480
`endif
) (
  input  logic        clk,
  input  logic        reset,
  line_cmd_if.slave   cmd,
  line_pix_if.master  pix,
  input  logic        abort_i,
  output logic        ls_calculate_o,
  output logic [15:0] ls_x1_o,
  output logic [15:0] ls_y1_o,
  output logic [15:0] ls_x2_o,
  output logic [15:0] ls_y2_o,
  output logic        ls_get_pixel_o,
  input  logic [15:0] ls_x_i,
  input  logic [15:0] ls_y_i,
  output logic        busy_o,
  output logic        line_done_o,
  output logic [15:0] pixels_drawn_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_EMIT   = 3'd3,
    ST_STEP   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        remain_q, remain_d;
  logic [15:0]        count_q, count_d;
  logic [15:0]        x1_q, y1_q, x2_q, y2_q;
  logic [COLOR_W-1:0] color_q;
  logic               cmd_ready_q, calc_q, step_q, busy_q, done_q;

  logic [15:0]        adx, ady, line_len;
  logic               accept_cmd, in_emit, off_screen, pix_fire, pix_advance;

  // Line length is the major-axis span; the subtraction order keeps |dx| exact for 16-bit inputs.
  assign adx      = (cmd.x2 >= cmd.x1) ? (cmd.x2 - cmd.x1) : (cmd.x1 - cmd.x2);
  assign ady      = (cmd.y2 >= cmd.y1) ? (cmd.y2 - cmd.y1) : (cmd.y1 - cmd.y2);
  assign line_len = (adx >= ady) ? adx : ady;

  assign accept_cmd = (state_q == ST_IDLE) && cmd_ready_q && cmd.valid;
  assign in_emit    = (state_q == ST_EMIT);

`ifdef LINE_CLIP_EN
  assign off_screen = (ls_x_i >= 16'(SCREEN_W)) || (ls_y_i >= 16'(SCREEN_H));
`else
  assign off_screen = 1'b0;
`endif

  // A clipped pixel is consumed internally without a write request.
  assign pix_fire    = in_emit && !off_screen && pix.ready;
  assign pix_advance = in_emit && (off_screen || pix.ready);

  assign cmd.ready      = cmd_ready_q;
  assign pix.valid      = in_emit && !off_screen;
  assign pix.x          = in_emit ? ls_x_i : 16'd0;
  assign pix.y          = in_emit ? ls_y_i : 16'd0;
  assign pix.color      = color_q;
  assign ls_x1_o        = x1_q;
  assign ls_y1_o        = y1_q;
  assign ls_x2_o        = x2_q;
  assign ls_y2_o        = y2_q;
  assign ls_calculate_o = calc_q;
  assign ls_get_pixel_o = step_q;
  assign busy_o         = busy_q;
  assign line_done_o    = done_q;
  assign pixels_drawn_o = count_q;

  // Next-state, remaining-pixel and accepted-pixel counter logic.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    count_d  = count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_cmd) begin
          state_d  = ST_LOAD;
          remain_d = line_len;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort_i) state_d = ST_DONE;
        else         state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (abort_i) state_d = ST_DONE;
        else         state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (pix_advance) begin
          if (abort_i || (remain_q == 16'd0)) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_STEP;
            remain_d = remain_q - 16'd1;
          end
        end else if (abort_i) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_STEP: begin
        if (abort_i) state_d = ST_DONE;
        else         state_d = ST_EMIT;
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        remain_d = 16'd0;
      end
      default: begin
        state_d  = ST_IDLE;
        remain_d = 16'd0;
      end
    endcase
    if (pix_fire && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // State, counters and pulse outputs; outputs are decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      remain_q    <= 16'd0;
      count_q     <= 16'd0;
      cmd_ready_q <= 1'b0;
      calc_q      <= 1'b0;
      step_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      count_q     <= count_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      calc_q      <= (state_d == ST_LOAD);
      step_q      <= (state_d == ST_STEP);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
    end
  end

  // Endpoint and colour latch, held for the whole line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x1_q    <= 16'd0;
      y1_q    <= 16'd0;
      x2_q    <= 16'd0;
      y2_q    <= 16'd0;
      color_q <= '0;
    end else if (accept_cmd) begin
      x1_q    <= cmd.x1;
      y1_q    <= cmd.y1;
      x2_q    <= cmd.x2;
      y2_q    <= cmd.y2;
      color_q <= cmd.color;
    end else begin
      x1_q    <= x1_q;
      y1_q    <= y1_q;
      x2_q    <= x2_q;
      y2_q    <= y2_q;
      color_q <= color_q;
    end
  end

endmodule

// File: doc/line_draw_ctrl.md
# line_draw_ctrl

Sequencer that sits between the GPU command decoder and the single-line pixel stepper. It accepts line commands over a valid/ready handshake and loads the stepper's endpoints with a one-cycle calculate pulse. It then presents each stepped coordinate with its colour to the framebuffer write port, advances the stepper only after the current pixel has been accepted, and signals completion. Line termination is by an internal pixel count, so behaviour does not depend on the stepper's completion timing.

## Interface
- SCREEN_W, 640, pixels per row; unsigned x must be < SCREEN_W to be on-screen
- SCREEN_H, 480, rows; unsigned y must be < SCREEN_H to be on-screen
- COLOR_W, 16, pixel colour width
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command (high only in IDLE)
- cmd_x1, cmd_y1, cmd_x2, cmd_y2  in  16 each  unsigned endpoints
- cmd_color  in  COLOR_W  line colour
- abort  in  1  synchronous; drops the current line
- ls_calculate  out  1  one-cycle pulse; stepper loads x1/y1 at that edge
- ls_x1, ls_y1, ls_x2, ls_y2  out  16 each  latched endpoints, held stable while the line is busy
- ls_get_pixel  out  1  one-cycle pulse; stepper advances one pixel at that edge
- ls_x, ls_y  in  16 each  stepper's current coordinate
- pix_valid  out  1  pixel write request
- pix_ready  in  1  framebuffer accepts
- pix_x, pix_y  out  16 each  pixel coordinate (equals ls_x/ls_y)
- pix_color  out  COLOR_W  latched colour
- busy  out  1  state != IDLE
- line_done  out  1  one-cycle pulse at line end (normal end or abort)
- pixels_drawn  out  16  saturating count of accepted pixels since reset

## Operation
- States: IDLE, LOAD, SETTLE, EMIT, STEP, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch the endpoints and colour, compute remaining = max(|x2-x1|,|y2-y1|) (16-bit), then go to LOAD.
- LOAD: ls_calculate=1 for one cycle, then SETTLE.
- SETTLE: one wait cycle so ls_x/ls_y carry x1/y1, then EMIT.
- EMIT: pix_valid=1. On pix_valid&pix_ready, pixels_drawn increments and saturates at 0xFFFF. Then:
  - if remaining==0, go to DONE;
  - otherwise decrement remaining and go to STEP.
- STEP: ls_get_pixel=1 for one cycle, then EMIT.
- Total per line: exactly remaining_initial ls_get_pixel pulses and remaining_initial+1 accepted pixels.
- DONE: line_done=1 for one cycle, then IDLE.
- A degenerate line (x1==x2, y1==y2) emits exactly one pixel.
- |dx| is computed as the absolute value of the 17-bit signed difference, truncated to 16 bits.
- abort in any state other than IDLE or DONE forces DONE on the next edge, with no further pixels and no further get_pixel pulses. abort in IDLE is ignored; cmd_ready stays 1.
- pix_valid, once raised, stays high with stable pix_x/pix_y/pix_color until accepted or aborted.

## Timing
- Reset values: cmd_ready=0 during reset and 1 from the first cycle after release; all other outputs 0; state=IDLE; remaining=0.
- Command accept to first pix_valid: 3 cycles (LOAD, SETTLE, then EMIT on the 3rd edge).
- Minimum 2 cycles per pixel (EMIT, STEP) with pix_ready held high.
- Last accept to line_done: 1 cycle. line_done to next cmd_ready: 1 cycle.
- Reset asserted mid-line: immediate return to IDLE with every output at its reset value. pixels_drawn clears. No line_done is generated.
- abort and pix_ready in the same EMIT cycle: the pixel counts as accepted (pixels_drawn increments), and the next state is DONE.

## Configuration
- LINE_CLIP_EN defined: in EMIT, if ls_x >= SCREEN_W or ls_y >= SCREEN_H, pix_valid stays 0. The pixel is treated as accepted internally, so remaining logic and stepping proceed, but pixels_drawn does not increment. Such a pixel costs 1 EMIT cycle.
- LINE_CLIP_EN undefined: every coordinate is presented unchanged, with no bound comparison logic.

## Test plan
- Horizontal (10,5)->(14,5), pix_ready=1 -> 5 pixels x=10..14 at y=5; 4 ls_get_pixel pulses; line_done 1 cycle after 5th accept; pixels_drawn=5.
- Point (7,7)->(7,7) -> one pixel (7,7); zero get_pixel pulses; line_done.
- Backpressure: (0,0)->(3,3) with pix_ready low for 4 cycles on the 2nd pixel -> pix_valid/pix_x/pix_y held stable; no get_pixel pulse until accept; 4 pixels total.
- Abort during the 3rd EMIT of a 10-pixel line -> pixels_drawn=2; line_done next cycle; cmd_ready the cycle after; next command runs normally.
- Reset pulse mid-STEP -> all outputs 0 and state IDLE without line_done; cmd_ready=1 after release.
- With LINE_CLIP_EN, SCREEN_W=640: (638,0)->(642,0) -> pix_valid for x=638,639 only; pixels_drawn=2; 4 get_pixel pulses; line_done.
